// File: rtl/game_timer_ctrl_pkg.sv
// Shared definitions for the snake-game round controller: state encodings,
// BCD limits and the two-digit BCD arithmetic helpers.
package game_timer_ctrl_pkg;

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_OVER  = 2'b11;

   localparam logic [7:0] BCD_ZERO = 8'h00;
   localparam logic [7:0] BCD_MAX  = 8'h99;

   // Borrow from tens when ones is 0; 0x00 never reaches here in RUN, but clamps anyway.
   function automatic logic [7:0] bcd_dec(input logic [7:0] t);
      logic [7:0] r;
      if (t[3:0] != 4'd0)
         r = {t[7:4], t[3:0] - 4'd1};
      else if (t[7:4] != 4'd0)
         r = {t[7:4] - 4'd1, 4'd9};
      else
         r = BCD_ZERO;
      return r;
   endfunction

   function automatic logic [7:0] bcd_add(input logic [7:0] t, input logic [3:0] b);
      logic [4:0] ones;
      logic [4:0] tens;
      logic [7:0] r;
      ones = {1'b0, t[3:0]} + {1'b0, b};
      tens = {1'b0, t[7:4]};
      if (ones > 5'd9) begin
         ones = ones - 5'd10;
         tens = tens + 5'd1;
      end
      if (tens > 5'd9)
         r = BCD_MAX;
      else
         r = {tens[3:0], ones[3:0]};
      return r;
   endfunction

endpackage

// File: rtl/game_timer_ctrl_tick_gen.sv
// Prescaler that divides the system clock down to one tick per CLK_HZ cycles.
// Holds its count while en is low so a paused round resumes mid-second.
module tick_gen #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(CLK_HZ);
   localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);

   logic [CW-1:0] count;

   assign tick = en && (count == TERM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= tick ? '0 : count + CW'(1);
   end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round controller: runs the BCD countdown through IDLE/RUN/PAUSE/OVER,
// applies eat bonuses and ends the round on expiry or collision.
module game_timer_ctrl
   import game_timer_ctrl_pkg::*;
#(
   parameter int          CLK_HZ    = 100_000_000,
   parameter logic [7:0]  INIT_BCD  = 8'h60,
   parameter int          BONUS_SEC = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       eat,
   input  logic       collide,
   output logic [7:0] time_bcd,
   output logic [1:0] state,
   output logic       running,
   output logic       tick_1s,
   output logic       game_over
);

   localparam logic [3:0] BONUS = 4'(BONUS_SEC);

   logic       tick;
   logic       restart;
   logic [1:0] state_nx;
   logic [7:0] time_nx;
   logic [7:0] time_step;
   logic       tick_nx;

   tick_gen #(.CLK_HZ(CLK_HZ)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (state == ST_RUN),
      .clr  (restart),
      .tick (tick)
   );

   // In RUN the decrement happens before the bonus so 0x01 plus eat lands on 0x05,
   // and only a tick that leaves zero on the clock ends the round.
   always_comb begin
      state_nx  = state;
      time_nx   = time_bcd;
      time_step = time_bcd;
      tick_nx   = 1'b0;
      restart   = 1'b0;
      case (state)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               state_nx = ST_RUN;
               time_nx  = INIT_BCD;
               restart  = 1'b1;
            end
         end
         ST_RUN: begin
            if (collide) begin
               state_nx = ST_OVER;
            end else begin
               if (tick)
                  time_step = bcd_dec(time_step);
               if (eat)
                  time_step = bcd_add(time_step, BONUS);
               time_nx = time_step;
               tick_nx = tick;
               if (tick && (time_step == BCD_ZERO))
                  state_nx = ST_OVER;
               else if (pause)
                  state_nx = ST_PAUSE;
            end
         end
         default: begin
            if (collide)
               state_nx = ST_OVER;
            else if (pause)
               state_nx = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         time_bcd  <= INIT_BCD;
         running   <= 1'b0;
         tick_1s   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         state     <= state_nx;
         time_bcd  <= time_nx;
         running   <= (state_nx == ST_RUN);
         tick_1s   <= tick_nx;
         game_over <= (state_nx == ST_OVER);
      end
   end

endmodule
